// File: rtl/ecc_mul_arb.sv
// Round-robin arbiter sharing one fixed-latency pipelined multiplier among NREQ
// requesters; a tag pipeline routes each result back to the requester that issued it.
module ecc_mul_arb #(
    parameter int  NREQ  = 4,
    parameter int  WIDTH = 16,
    parameter int  LAT   = 4,
    localparam int TW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int IW    = $clog2(LAT + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [NREQ*WIDTH-1:0] req_opa,
    input  logic [NREQ*WIDTH-1:0] req_opb,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  iss_vld,
    output logic [WIDTH-1:0]      iss_opa,
    output logic [WIDTH-1:0]      iss_opb,
    output logic [TW-1:0]         iss_tag,
    input  logic [WIDTH-1:0]      res_dat,
    output logic [NREQ-1:0]       rsp_vld,
    output logic [WIDTH-1:0]      rsp_dat,
    output logic [IW-1:0]         inflight
);

    logic [TW-1:0]  ptr;
    logic [TW-1:0]  gnt_idx;
    logic [TW-1:0]  cand;
    logic           gnt_any;
    logic           hs;
    logic           rsp_any;
    logic [LAT-1:0] pipe_vld;
    logic [TW-1:0]  pipe_tag [LAT];

    // NOTE: every variable written in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = TW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && req_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign hs      = gnt_any && !hold;
    assign req_rdy = hs ? (NREQ'(1) << gnt_idx) : '0;
    assign rsp_any = |rsp_vld;

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            iss_vld <= 1'b0;
            iss_opa <= '0;
            iss_opb <= '0;
            iss_tag <= '0;
        end else begin
            iss_vld <= hs;
            if (hs) begin
                iss_opa <= req_opa[int'(gnt_idx)*WIDTH +: WIDTH];
                iss_opb <= req_opb[int'(gnt_idx)*WIDTH +: WIDTH];
                iss_tag <= gnt_idx;
                ptr     <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + TW'(1);
            end
        end
    end

    // The tag pipeline never stalls, so its last stage lines up with res_dat of the same op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= iss_vld;
            for (int k = 1; k < LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
            end
        end
    end

    // NOTE: the tag array carries no reset; a tag is only consumed when its pipe_vld bit is set.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= iss_tag;
        for (int k = 1; k < LAT; k++) begin
            pipe_tag[k] <= pipe_tag[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= '0;
            rsp_dat <= '0;
        end else begin
            rsp_vld <= pipe_vld[LAT-1] ? (NREQ'(1) << pipe_tag[LAT-1]) : '0;
            if (pipe_vld[LAT-1]) begin
                rsp_dat <= res_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({hs, rsp_any})
                2'b10:   inflight <= inflight + IW'(1);
                2'b01:   inflight <= inflight - IW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
